serial_subtractor: RTL and testbench

//  Bit-serial full subtractor: computes {bout,diff} = a - b - bin, LSB first, one bit per clock.
//  The datapath is a single full-subtractor cell plus a borrow flip-flop.
//  It is the arithmetic inverse of the combinational adder blocks. Operands arrive on a valid/ready

---
 rtl/serial_subtractor.sv | 111 +++++++++++
 tb/tb_serial_subtractor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {bout,diff} = a - b - bin, one bit per clock, LSB first.
// One full-subtractor cell and a borrow flop, with valid/ready handshakes on both sides.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // CALC  | one difference bit produced per edge
    // DONE  | result held, out_valid high until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             d_bit;
    logic             brw_nxt;

    assign d_bit   = a_q[0] ^ b_q[0] ^ brw_q;
    assign brw_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Result bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                brw_d  = brw_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bout_d  = brw_nxt;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit instance for directed cases and
// a 4-bit instance for an exhaustive back-to-back sweep with random output stalls.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8;
    logic [7:0] a8, b8, diff8;

    logic       in_valid4, in_ready4, bin4, out_valid4, out_ready4, bout4;
    logic [3:0] a4, b4, diff4;

    int n_checks;
    int n_fail;

    logic [8:0] q8[$];
    logic [4:0] q4[$];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .bin(bin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .bout(bout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] model8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        return {1'b0, av} - {1'b0, bv} - {8'd0, bi};
    endfunction

    // Waits for in_ready, drives operands at a falling edge, returns just after the accept edge.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready8 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a8 = av; b8 = bv; bin8 = bi; in_valid8 = 1'b1;
        q8.push_back(model8(av, bv, bi));
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        a8 = 8'hA5; b8 = 8'h5A; bin8 = 1'b1;
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({in_ready8, out_valid8, diff8, bout8} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset8: got rdy=%b vld=%b diff=%h bout=%b, want rdy=1 vld=0 diff=00 bout=0",
                     in_ready8, out_valid8, diff8, bout8);
        end
        n_checks++;
        if ({in_ready4, out_valid4, diff4, bout4} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset4: got rdy=%b vld=%b diff=%h bout=%b, want rdy=1 vld=0 diff=0 bout=0",
                     in_ready4, out_valid4, diff4, bout4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0] ta[5] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h80};
        logic [7:0] tb[5] = '{8'h03, 8'h05, 8'h00, 8'hFF, 8'h7F};
        logic       tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [8:0] exp;
        int lat;
        out_ready8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue8(ta[i], tb[i], tc[i]);
            wait_done8(lat);
            n_checks++;
            if (lat != 8) begin
                n_fail++;
                $display("FAIL latency case %0d: got %0d edges, want 8", i, lat);
            end
            exp = (q8.size() > 0) ? q8.pop_front() : 9'h1XX;
            n_checks++;
            if ({bout8, diff8} !== exp) begin
                n_fail++;
                $display("FAIL result case %0d: got bout=%b diff=%h, want bout=%b diff=%h",
                         i, bout8, diff8, exp[8], exp[7:0]);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({out_valid8, in_ready8} !== 2'b01) begin
                n_fail++;
                $display("FAIL handshake case %0d: got vld=%b rdy=%b, want vld=0 rdy=1",
                         i, out_valid8, in_ready8);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [8:0] exp;
        int lat;
        out_ready8 = 1'b0;
        issue8(8'h37, 8'h12, 1'b1);
        exp = (q8.size() > 0) ? q8.pop_front() : 9'h1XX;
        wait_done8(lat);
        // Offer a new operand while stalled; it must not be taken.
        a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1; in_valid8 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({out_valid8, in_ready8, bout8, diff8} !== {1'b1, 1'b0, exp}) begin
                n_fail++;
                $display("FAIL stall cycle %0d: got vld=%b rdy=%b bout=%b diff=%h, want vld=1 rdy=0 bout=%b diff=%h",
                         c, out_valid8, in_ready8, bout8, diff8, exp[8], exp[7:0]);
            end
            @(posedge clk);
            #1;
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid8, in_ready8} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall release: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid8, in_ready8);
        end
    endtask

    task automatic test_reset_abort;
        logic [8:0] exp;
        int lat;
        out_ready8 = 1'b1;
        issue8(8'hC3, 8'h21, 1'b0);
        void'(q8.pop_back());
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid8, in_ready8, diff8, bout8} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL abort: got vld=%b rdy=%b diff=%h bout=%b, want vld=0 rdy=1 diff=00 bout=0",
                     out_valid8, in_ready8, diff8, bout8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue8(8'd9, 8'd4, 1'b0);
        wait_done8(lat);
        exp = (q8.size() > 0) ? q8.pop_front() : 9'h1XX;
        n_checks++;
        if ({bout8, diff8} !== exp || lat != 8) begin
            n_fail++;
            $display("FAIL after abort: got bout=%b diff=%h lat=%0d, want bout=%b diff=%h lat=8",
                     bout8, diff8, lat, exp[8], exp[7:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int sent;
        int got;
        sent = 0;
        got  = 0;
        fork
            begin : driver
                int cyc;
                logic [8:0] idx;
                cyc = 0;
                while (sent < 512 && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    idx = 9'(sent);
                    a4 = idx[3:0]; b4 = idx[7:4]; bin4 = idx[8];
                    in_valid4 = 1'b1;
                    if (in_ready4) begin
                        q4.push_back({1'b0, idx[3:0]} - {1'b0, idx[7:4]} - {4'd0, idx[8]});
                        sent++;
                    end
                end
                @(negedge clk);
                in_valid4 = 1'b0;
            end
            begin : monitor
                int cyc;
                logic [4:0] exp;
                cyc = 0;
                while (got < 512 && cyc < 25000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready4 = ($urandom_range(0, 3) != 0);
                    if (out_valid4 && out_ready4) begin
                        n_checks++;
                        if (q4.size() == 0) begin
                            n_fail++;
                            $display("FAIL b2b result %0d: got bout=%b diff=%h, want nothing (queue empty)",
                                     got, bout4, diff4);
                        end else begin
                            exp = q4.pop_front();
                            if ({bout4, diff4} !== exp) begin
                                n_fail++;
                                $display("FAIL b2b result %0d: got bout=%b diff=%h, want bout=%b diff=%h",
                                         got, bout4, diff4, exp[4], exp[3:0]);
                            end
                        end
                        got++;
                    end
                end
                out_ready4 = 1'b0;
            end
        join
        n_checks++;
        if (got != 512 || sent != 512 || q4.size() != 0) begin
            n_fail++;
            $display("FAIL b2b count: got sent=%0d received=%0d left=%0d, want 512 512 0",
                     sent, got, q4.size());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0; out_ready8 = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0; out_ready4 = 1'b0;
        test_reset;
        test_basic;
        test_backpressure;
        test_reset_abort;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
